// File: rtl/gnr_attractor_ctrl.sv
// ---------------------------------------------------------------------------
// gnr_attractor_ctrl
//   Sequencer/reader for an array of boolean-network nodes. Each node holds a
//   half-rate state s0 (tortoise) and a full-rate state s1 (hare). The block
//   loads an initial vector into the nodes, steps them until the tortoise and
//   hare meet (Floyd cycle detection), then steps only the hare until it
//   returns to the meeting state to measure the attractor period.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   start            run request, accepted in IDLE only
//   init_vec         initial network state, latched on start acceptance
//   s0_vec, s1_vec   node tortoise / hare states read back from the array
//   reset_nos        node load strobe (one cycle per run)
//   init_state       per-node load value
//   start_s0         tortoise step strobe
//   start_s1         hare step strobe
//   busy             run in progress (start acceptance through DONE)
//   done             one-cycle completion pulse
//   found            attractor detected; held until next accepted start
//   steps            strobes issued up to the meeting point
//   period           attractor period
//   attractor_state  s0_vec at the meeting point
// ---------------------------------------------------------------------------
module gnr_attractor_ctrl #(
  parameter int N_NODES   = 16,
  parameter int CNT_W     = 32,
  // Must be < 2**CNT_W so the budget check stops a run before any wrap.
  parameter int MAX_STEPS = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_vec,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [CNT_W-1:0]   steps,
  output logic [CNT_W-1:0]   period,
  output logic [N_NODES-1:0] attractor_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STEP   = 3'd2,
    CHECK  = 3'd3,
    PSTEP  = 3'd4,
    PCHECK = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] K_MIN   = CNT_W'(2);

  state_t           state;
  logic [CNT_W-1:0] k_cnt;
  logic [CNT_W-1:0] p_cnt;

  // All outputs are registered. Strobes and reset_nos are raised on the
  // transition into the state that owns them, so they are high for exactly
  // the one cycle spent in LOAD / STEP / PSTEP and can never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      k_cnt           <= '0;
      p_cnt           <= '0;
      reset_nos       <= 1'b0;
      init_state      <= '0;
      start_s0        <= 1'b0;
      start_s1        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      found           <= 1'b0;
      steps           <= '0;
      period          <= '0;
      attractor_state <= '0;
    end else begin
      reset_nos <= 1'b0;
      start_s0  <= 1'b0;
      start_s1  <= 1'b0;
      done      <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            init_state      <= init_vec;
            k_cnt           <= '0;
            p_cnt           <= '0;
            steps           <= '0;
            period          <= '0;
            found           <= 1'b0;
            attractor_state <= '0;
            busy            <= 1'b1;
            reset_nos       <= 1'b1;
            state           <= LOAD;
          end
        end

        LOAD: begin
          start_s0 <= 1'b1;
          start_s1 <= 1'b1;
          k_cnt    <= k_cnt + 1'b1;
          state    <= STEP;
        end

        STEP: state <= CHECK;

        CHECK: begin
          // k=1 always matches (both states are f(x0)), so require k>=2.
          if ((k_cnt >= K_MIN) && (s0_vec == s1_vec)) begin
            steps           <= k_cnt;
            attractor_state <= s0_vec;
            start_s1        <= 1'b1;
            p_cnt           <= CNT_W'(1);
            state           <= PSTEP;
          end else if (k_cnt == MAX_CNT) begin
            found <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            start_s0 <= 1'b1;
            start_s1 <= 1'b1;
            k_cnt    <= k_cnt + 1'b1;
            state    <= STEP;
          end
        end

        PSTEP: state <= PCHECK;

        PCHECK: begin
          if (s1_vec == attractor_state) begin
            period <= p_cnt;
            found  <= 1'b1;
            done   <= 1'b1;
            state  <= DONE;
          end else if (p_cnt == MAX_CNT) begin
            found <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            start_s1 <= 1'b1;
            p_cnt    <= p_cnt + 1'b1;
            state    <= PSTEP;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
